uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx_8n1 transmitter between NREQ byte producers (e.g. counter
//  demo, keypad echo, status reporter). Round-robin arbitration per byte:
//  latches the winner's byte, drives the transmitter start handshake, waits for
//  completion, then optionally inserts an idle gap. Sits between the producers
//  and the transmitter, entirely in the hwclk domain.
// PARAMETERS
//  NREQ        4   number of requesters, 2..8
//  GAP_CYCLES  0   hwclk cycles of forced idle after each byte; 0 = no gap state
// PORTS
//  hwclk      in   1       system clock (12 MHz)
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   NREQ    requester i has a byte; held high until req_ready[i]
//  req_data   in   8*NREQ  byte of requester i at [8*i+7:8*i]
//  req_last   in   NREQ    byte i ends a packet (used only with PKT_LOCK_EN)
//  req_ready  out  NREQ    one-cycle pulse: byte i accepted
//  grant      out  NREQ    one-hot owner of transmitter; 0 when idle
//  tx_byte    out  8       byte to transmitter, stable while tx_send high
//  tx_send    out  1       start request, held high until tx_done
//  tx_done    in   1       one-cycle completion pulse from transmitter (hwclk domain)
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; req_ready, grant, tx_send, busy = 0; tx_byte = 8'h00;
//    rr pointer last = NREQ-1 (requester 0 highest priority after reset).
//  - All outputs registered. States: IDLE, SEND, GAP.
//  - IDLE: if any req_valid, winner = first valid index scanning last+1, last+2..
//    mod NREQ. On that edge: grant<=onehot(winner), tx_byte<=req_data[winner],
//    req_ready[winner]<=1 (one cycle), tx_send<=1, last<=winner, state<=SEND.
//    Latency: valid sampled in cycle n -> req_ready and tx_send high in cycle n+1.
//  - SEND: tx_send, grant, tx_byte held. On tx_done: tx_send<=0, grant<=0; go GAP
//    if GAP_CYCLES>0 (counter loaded GAP_CYCLES-1) else IDLE. New arbitration
//    earliest cycle after tx_done falls, so back-to-back bytes have >=1 idle cycle.
//  - GAP: count down to 0, then IDLE. Counter width $clog2(GAP_CYCLES+1).
//  - tx_done outside SEND ignored. req_valid sampled only in IDLE; deasserting
//    valid before ready is a protocol violation (no recovery required).
//  - Simultaneous requests: strict rotation; a continuously valid requester
//    waits at most NREQ-1 other bytes.
//  - Reset mid-SEND: tx_send drops asynchronously; byte lost, requester already
//    saw req_ready, no retry.
// CONFIGURATION
//  PKT_LOCK_EN defined: after a byte from i with req_last[i]=0, lock to i; IDLE
//   grants only i (waits indefinitely for req_valid[i]); lock clears when a byte
//   with req_last[i]=1 is accepted or on reset. Extra output locked (1 bit,
//   reset 0) high while lock held.
//  PKT_LOCK_EN undefined: req_last ignored, every byte re-arbitrated, no locked port.
// TESTING
//  1 reset, req_valid=4'b0001, data0=8'h30 -> ready[0] and tx_send next cycle,
//    tx_byte=8'h30, grant=0001; tx_done -> tx_send=0, busy=0 next cycle.
//  2 all four valid constantly, data i=8'h41+i -> tx order 41,42,43,44,41; each
//    ready exactly once per rotation.
//  3 GAP_CYCLES=3: tx_done at cycle t -> busy high cycles t+1..t+3, next tx_send
//    at t+5 with another request pending.
//  4 tx_done pulsed in IDLE with no requests -> no output change.
//  5 rst_n low 2 cycles mid-SEND -> tx_send, grant, busy 0 immediately; after
//    release requester 0 wins over 1 when both valid.
//  6 PKT_LOCK_EN: req0 sends 'A'(last=0),'B'(last=1) while req1 valid -> order
//    A,B, then req1; locked high only between A accept and B accept.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter among NREQ byte producers.
// Optional packet lock (define PKT_LOCK_EN) keeps the grant on one requester until req_last.
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_byte,
    output logic              tx_send,
    input  logic              tx_done,
`ifdef PKT_LOCK_EN
    output logic              locked,
`endif
    output logic              busy
);

    localparam int LW = $clog2(NREQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [GW-1:0]   cnt;
    logic [LW-1:0]   win;
    logic            any;
    int              idx;

`ifdef PKT_LOCK_EN
    logic            lock;
    logic [LW-1:0]   lock_id;
    assign locked = lock;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Scan descending so the nearest valid index after last wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (req_valid[idx]) begin
                win = LW'(idx);
                any = 1'b1;
            end
        end
`ifdef PKT_LOCK_EN
        if (lock) begin
            win = lock_id;
            any = req_valid[lock_id];
        end
`endif
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= LW'(NREQ - 1);
            cnt       <= '0;
            req_ready <= '0;
            grant     <= '0;
            tx_byte   <= 8'h00;
            tx_send   <= 1'b0;
            busy      <= 1'b0;
`ifdef PKT_LOCK_EN
            lock      <= 1'b0;
            lock_id   <= '0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        tx_byte   <= req_data[8*win +: 8];
                        tx_send   <= 1'b1;
                        busy      <= 1'b1;
                        last      <= win;
                        state     <= SEND;
`ifdef PKT_LOCK_EN
                        lock      <= ~req_last[win];
                        lock_id   <= win;
`endif
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        tx_send <= 1'b0;
                        grant   <= '0;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus hand sequences for
// rotation, gap timing, async reset and (when PKT_LOCK_EN) packet lock.
module tb_uart_tx_arbiter;

    logic        hwclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid = '0, last = '0;
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic        done = 1'b0;
    logic [3:0]  ready, grant;
    logic [7:0]  tx_byte;
    logic        tx_send, busy;
`ifdef PKT_LOCK_EN
    logic        locked;
`endif

    // Second instance exercises the idle-gap variant with its own stimulus.
    logic [3:0]  valid2 = '0;
    logic [7:0]  g0 = 8'h10, g1 = 8'h20;
    logic        done2 = 1'b0;
    logic [3:0]  ready2, grant2;
    logic [7:0]  tx_byte2;
    logic        tx_send2, busy2;
`ifdef PKT_LOCK_EN
    logic        locked2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 hwclk = ~hwclk;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0)) dut (
        .hwclk(hwclk), .rst_n(rst_n), .req_valid(valid), .req_data({d3, d2, d1, d0}),
        .req_last(last), .req_ready(ready), .grant(grant), .tx_byte(tx_byte),
        .tx_send(tx_send), .tx_done(done),
`ifdef PKT_LOCK_EN
        .locked(locked),
`endif
        .busy(busy));

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(3)) dut_gap (
        .hwclk(hwclk), .rst_n(rst_n), .req_valid(valid2), .req_data({8'h00, 8'h00, g1, g0}),
        .req_last(4'b1111), .req_ready(ready2), .grant(grant2), .tx_byte(tx_byte2),
        .tx_send(tx_send2), .tx_done(done2),
`ifdef PKT_LOCK_EN
        .locked(locked2),
`endif
        .busy(busy2));

    typedef struct {
        logic [3:0] valid;
        logic [7:0] d0, d1;
        logic       done;
        logic [3:0] e_ready, e_grant;
        logic       e_send;
        logic [7:0] e_byte;
        logic       e_busy;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_r;
        logic       found;

        // Outputs: ready, grant, send, byte, busy after the edge that sampled the row.
        tbl[0] = '{4'b0001, 8'h30, 8'h00, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h30, 1'b1};
        tbl[1] = '{4'b0000, 8'h30, 8'h00, 1'b0, 4'b0000, 4'b0001, 1'b1, 8'h30, 1'b1};
        tbl[2] = '{4'b0000, 8'h30, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h30, 1'b0};
        tbl[3] = '{4'b0000, 8'h30, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h30, 1'b0};
        tbl[4] = '{4'b0000, 8'h30, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h30, 1'b0};
        tbl[5] = '{4'b0010, 8'h30, 8'h55, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h55, 1'b1};
        tbl[6] = '{4'b0000, 8'h30, 8'h55, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h55, 1'b0};
        tbl[7] = '{4'b1001, 8'h30, 8'h55, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h77, 1'b1};
        tbl[8] = '{4'b0000, 8'h30, 8'h55, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h77, 1'b0};

        d3 = 8'h77;
        tick();
        tick();
        chk("rst_ready", ready, 4'b0);
        chk("rst_grant", grant, 4'b0);
        chk("rst_send", tx_send, 1'b0);
        chk("rst_byte", tx_byte, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            valid = tbl[i].valid;
            d0 = tbl[i].d0;
            d1 = tbl[i].d1;
            done = tbl[i].done;
            tick();
            chk($sformatf("v%0d_ready", i), ready, tbl[i].e_ready);
            chk($sformatf("v%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("v%0d_send", i), tx_send, tbl[i].e_send);
            chk($sformatf("v%0d_byte", i), tx_byte, tbl[i].e_byte);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
        end
        done = 1'b0;

        // Rotation with all four continuously valid.
        rst_n = 1'b0;
        tick();
        d0 = 8'h41; d1 = 8'h42; d2 = 8'h43; d3 = 8'h44;
        valid = 4'b1111;
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                tick();
                if (tx_send) found = 1'b1;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL rot%0d_timeout actual=no_send expected=send", n);
            end else begin
                exp_r = 4'b0001 << (n % 4);
                chk($sformatf("rot%0d_byte", n), tx_byte, 8'h41 + 8'(n % 4));
                chk($sformatf("rot%0d_ready", n), ready, exp_r);
                chk($sformatf("rot%0d_grant", n), grant, exp_r);
            end
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            chk($sformatf("rot%0d_drop", n), tx_send, 1'b0);
        end

        // Async reset mid-SEND, then requester 0 beats 1.
        valid = 4'b0100;
        tick();
        chk("pre_rst_grant", grant, 4'b0100);
        valid = 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_send", tx_send, 1'b0);
        chk("arst_grant", grant, 4'b0);
        chk("arst_busy", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", grant, 4'b0001);
        chk("post_rst_ready", ready, 4'b0001);
        chk("post_rst_byte", tx_byte, 8'h41);
        valid = 4'b0000;
        done = 1'b1;
        tick();
        done = 1'b0;

        // Gap of 3 cycles: busy t+1..t+3, next send at t+5.
        valid2 = 4'b0001;
        tick();
        chk("gap_first_send", tx_send2, 1'b1);
        valid2 = 4'b0010;
        tick();
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("gap_busy_t%0d", k), busy2, (k == 4) ? 1'b0 : 1'b1);
            chk($sformatf("gap_send_t%0d", k), tx_send2, (k == 5) ? 1'b1 : 1'b0);
            if (k < 5) tick();
        end
        chk("gap_second_grant", grant2, 4'b0010);
        chk("gap_second_byte", tx_byte2, 8'h20);
        valid2 = 4'b0000;

`ifdef PKT_LOCK_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("lock_rst", locked, 1'b0);
        d0 = 8'h41; d1 = 8'h5A; last = 4'b0000;
        valid = 4'b0011;
        tick();
        chk("lock_a_byte", tx_byte, 8'h41);
        chk("lock_a_locked", locked, 1'b1);
        d0 = 8'h42; last = 4'b0001;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("lock_hold", locked, 1'b1);
        tick();
        chk("lock_b_byte", tx_byte, 8'h42);
        chk("lock_b_grant", grant, 4'b0001);
        chk("lock_b_locked", locked, 1'b0);
        valid = 4'b0010;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("lock_z_grant", grant, 4'b0010);
        chk("lock_z_byte", tx_byte, 8'h5A);
        valid = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
